pipe_trace_monitor: RTL and testbench
=====================================

# pipe_trace_monitor

Parametrised debug monitor that sits beside the `cpu` core in simulation and FPGA bring-up builds. It sequences the core's reset and counts executed cycles. It captures a configurable set of pipeline probe channels (IF/ID/EX/M/WB values) into a circular trace buffer and stops on HALT, opcode error, function-code error or cycle timeout. The captured trace, timestamps and stop cause are then read back through a simple random-access port.

## Interface
- NUM_CH, 4: number of probe channels.
- CH_W, 16: width of each probe channel.
- DEPTH, 8: trace entries; power of two, ≥2. AW = log2(DEPTH).
- RST_HOLD, 2: cycles `core_reset` stays high after `reset` deasserts.
- MAX_CYCLES, 0: timeout in counted cycles; 0 disables timeout.
- CNT_W, 32: cycle counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- core_reset  out  1  active-high reset driven to the core.
- probe  in  NUM_CH*CH_W  channel i at bits [i*CH_W +: CH_W].
- ch_en  in  NUM_CH  channel capture mask; disabled channels store 0.
- halt, op_err, fn_err  in  1 each  stop events from the core.
- arm  in  1  start capture (level sampled in IDLE).
- post_trig  in  AW+1  samples to record after the trigger sample; clamp to DEPTH-1.
- state  out  3  HOLD=0, IDLE=1, ARMED=2, POST=3, DONE=4.
- cycle_count  out  CNT_W  counted core cycles.
- stop_cause  out  4  {timeout, fn_err, op_err, halt}.
- done  out  1  state==DONE.
- entries  out  AW+1  valid trace entries.
- rd_en  in  1, rd_addr  in  AW  read request; addr 0 = oldest entry.
- rd_valid  out  1, rd_data  out  NUM_CH*CH_W, rd_cycle  out  CNT_W  read response.

## Operation
- Reset (reset=0 at an edge) sets the following. Buffer RAM contents are not cleared.
  - state=HOLD, hold counter=RST_HOLD, core_reset=1, cycle_count=0, stop_cause=0, entries=0, wr_ptr=0.
  - rd_valid=0, rd_data=0, rd_cycle=0.
- HOLD:
  - Each edge with reset=1 and hold counter≠0 decrements the counter.
  - At counter=0 → IDLE and core_reset=0. With RST_HOLD=0, the first edge with reset=1 goes straight to IDLE.
  - halt/op_err/fn_err are ignored in HOLD.
- cycle_count increments on every edge in IDLE, ARMED and POST, and saturates at all-ones.
- trig = halt | op_err | fn_err | (MAX_CYCLES≠0 && cycle_count ≥ MAX_CYCLES), evaluated in IDLE/ARMED/POST only.
- IDLE:
  - trig → DONE, stop_cause latched, no sample written. trig takes priority over arm.
  - Otherwise arm=1 → ARMED.
- ARMED:
  - Each edge writes {masked probe, cycle_count} at wr_ptr; wr_ptr increments mod DEPTH; entries saturates at DEPTH, after which the oldest entry is overwritten.
  - On trig: that cycle's sample is written, stop_cause latched, post counter=post_trig. Then → DONE if post_trig=0, else → POST.
- POST:
  - Writes one sample per edge and decrements the post counter; reaching 0 → DONE.
  - Further triggers do not change stop_cause.
- stop_cause latches only the trig bits of the first trigger edge; several bits may be set together.
- DONE:
  - Freezes the counter, buffer and stop_cause. Exit is by reset only.
  - Reads: physical index = (wr_ptr − entries + rd_addr) mod DEPTH.
- Reads outside DONE, or with rd_addr ≥ entries, return rd_valid=0 and zero data.

## Timing
- core_reset falls RST_HOLD+1 edges after the first edge sampling reset=1.
- cycle_count reads 1 after the first edge spent in IDLE.
- Trigger-to-done latency:
  - IDLE: 1 edge.
  - ARMED with post_trig=N: N+1 edges after the trigger edge.
- Read latency is 1 cycle. rd_valid/rd_data/rd_cycle are registered from the rd_en edge and hold until the next edge; rd_en=0 clears rd_valid.
- Reset asserted mid-capture aborts on that edge with all outputs at reset values.

## Test plan
- Reset release, RST_HOLD=2 → core_reset high for 3 edges after reset=1. state HOLD→IDLE, then cycle_count 1,2,3…
- Arm at cycle 5, halt pulse at cycle 10, post_trig=2 → samples written for cycles 5–12, entries=8. done at the edge after cycle 12; stop_cause=0001; rd_addr 0 returns rd_cycle=5.
- Wrap: DEPTH=8, arm at 1, op_err at 20, post_trig=0 → entries=8; rd_addr 0..7 return rd_cycle 13..20; stop_cause=0010.
- MAX_CYCLES=50, no arm → DONE when cycle_count=50, stop_cause=1000, entries=0; any read gives rd_valid=0.
- ch_en=4'b0101 with probe channels 0xAAAA/0xBBBB/0xCCCC/0xDDDD → stored word has channels 1 and 3 at 0.
- Simultaneous halt+fn_err in ARMED → stop_cause=0101. A later op_err in POST leaves it unchanged. reset=0 during POST → state HOLD and entries=0 next cycle.

Source files
------------

// File: rtl/pipe_trace_monitor_if.sv
// rtl/pipe_trace_monitor_if.sv - random-access trace read port
// Purpose: groups the trace read request/response signals.
// Ports:
//   rd_en, rd_addr           request (addr 0 = oldest valid entry)
//   rd_valid, rd_data,
//   rd_cycle                 registered response, one cycle after request
// Modports: master drives requests, slave (the monitor) drives responses.
interface pipe_trace_monitor_if #(
  parameter int AW    = 3,
  parameter int DW    = 64,
  parameter int CNT_W = 32
) ();
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] rd_cycle;

  modport master (
    output rd_en, rd_addr,
    input  rd_valid, rd_data, rd_cycle
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_valid, rd_data, rd_cycle
  );
endinterface

// File: rtl/pipe_trace_monitor.sv
// rtl/pipe_trace_monitor.sv - core reset sequencer, cycle counter and pipeline trace capture
// Purpose: holds the core in reset for RST_HOLD cycles, counts core cycles,
//   captures masked probe channels plus timestamps into a circular buffer
//   until a stop event (halt, opcode error, function error, timeout) and
//   a configurable number of post-trigger samples, then serves read-back.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   core_reset          active-high reset to the core
//   probe, ch_en        probe channels and capture mask
//   halt, op_err,
//   fn_err              stop events from the core
//   arm, post_trig      capture start and post-trigger sample count
//   state, cycle_count,
//   stop_cause, done,
//   entries             status
//   rd                  read port (slave side)
module pipe_trace_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 16,
  parameter int DEPTH      = 8,
  parameter int RST_HOLD   = 2,
  parameter int MAX_CYCLES = 0,
  parameter int CNT_W      = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int DW        = NUM_CH * CH_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              core_reset,
  input  logic [DW-1:0]     probe,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              halt,
  input  logic              op_err,
  input  logic              fn_err,
  input  logic              arm,
  input  logic [AW:0]       post_trig,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [3:0]        stop_cause,
  output logic              done,
  output logic [AW:0]       entries,
  pipe_trace_monitor_if.slave rd
);

  localparam int HW = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0]    HOLD_INIT = HW'(RST_HOLD);
  localparam logic [AW:0]      DEPTH_E   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      POST_MAX  = (AW + 1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_IDLE  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [HW-1:0]    r_hold_cnt;
  logic [CNT_W-1:0] r_cycle;
  logic [3:0]       r_stop;
  logic [AW:0]      r_entries;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_post_cnt;
  logic             r_rd_valid;
  logic [DW-1:0]    r_rd_data;
  logic [CNT_W-1:0] r_rd_cycle;

  logic [DW-1:0]    r_mem_data [DEPTH];
  logic [CNT_W-1:0] r_mem_cyc  [DEPTH];

  logic             w_active;
  logic             w_timeout;
  logic [3:0]       w_trig_bits;
  logic             w_trig;
  logic             w_wr;
  logic             w_latch;
  logic [AW:0]      w_post_clamp;
  logic [DW-1:0]    w_masked;
  logic [AW-1:0]    w_rd_idx;
  logic             w_rd_ok;

  assign w_active     = (r_state == S_IDLE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_timeout    = (MAX_CYCLES != 0) && (r_cycle >= MAX_C);
  assign w_trig_bits  = {w_timeout, fn_err, op_err, halt};
  assign w_trig       = w_active && (|w_trig_bits);
  assign w_post_clamp = (post_trig > POST_MAX) ? POST_MAX : post_trig;

  // Oldest entry sits 'entries' slots behind the write pointer; with a full
  // buffer the low AW bits of entries are zero, so this is wr_ptr itself.
  assign w_rd_idx = r_wr_ptr - r_entries[AW-1:0] + rd.rd_addr;
  assign w_rd_ok  = rd.rd_en && (r_state == S_DONE) && ({1'b0, rd.rd_addr} < r_entries);

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i]) begin
        w_masked[i*CH_W +: CH_W] = probe[i*CH_W +: CH_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_trig) begin
          w_latch     = 1'b1;
          w_state_nxt = S_DONE;
        end else if (arm) begin
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        w_wr = 1'b1;
        if (w_trig) begin
          w_latch     = 1'b1;
          w_state_nxt = (w_post_clamp == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        w_wr = 1'b1;
        if (r_post_cnt <= (AW + 1)'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hold_cnt <= HOLD_INIT;
      r_cycle    <= '0;
      r_stop     <= '0;
      r_entries  <= '0;
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_cycle <= '0;
    end else begin
      if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      if (w_active && (r_cycle != '1)) begin
        r_cycle <= r_cycle + 1'b1;
      end
      if (w_latch) begin
        r_stop <= w_trig_bits;
      end
      if (w_latch && (r_state == S_ARMED)) begin
        r_post_cnt <= w_post_clamp;
      end else if (r_state == S_POST) begin
        r_post_cnt <= r_post_cnt - 1'b1;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_entries != DEPTH_E) begin
          r_entries <= r_entries + 1'b1;
        end
      end
      if (w_rd_ok) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_mem_data[w_rd_idx];
        r_rd_cycle <= r_mem_cyc[w_rd_idx];
      end else begin
        r_rd_valid <= 1'b0;
        r_rd_data  <= '0;
        r_rd_cycle <= '0;
      end
    end
  end

  // Trace RAM keeps its contents across reset; only the write is gated.
  always_ff @(posedge clock) begin
    if (reset && w_wr) begin
      r_mem_data[r_wr_ptr] <= w_masked;
      r_mem_cyc[r_wr_ptr]  <= r_cycle;
    end
  end

  assign core_reset  = (r_state == S_HOLD);
  assign state       = r_state;
  assign cycle_count = r_cycle;
  assign stop_cause  = r_stop;
  assign done        = (r_state == S_DONE);
  assign entries     = r_entries;
  assign rd.rd_valid = r_rd_valid;
  assign rd.rd_data  = r_rd_data;
  assign rd.rd_cycle = r_rd_cycle;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// tb/tb_pipe_trace_monitor.sv - self-checking bench for pipe_trace_monitor
module tb_pipe_trace_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] probe;
  logic [3:0]  ch_en;
  logic        halt, op_err, fn_err, arm;
  logic [3:0]  post_trig;
  logic        rd_en;
  logic [2:0]  rd_addr;

  logic        core_reset0, core_reset1;
  logic [2:0]  state0, state1;
  logic [31:0] cycle_count0, cycle_count1;
  logic [3:0]  stop_cause0, stop_cause1;
  logic        done0, done1;
  logic [3:0]  entries0, entries1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] probe_at [0:255];

  always #5 clock = ~clock;

  pipe_trace_monitor_if #(.AW(3), .DW(64), .CNT_W(32)) rif0 ();
  pipe_trace_monitor_if #(.AW(3), .DW(64), .CNT_W(32)) rif1 ();
  assign rif0.rd_en   = rd_en;
  assign rif0.rd_addr = rd_addr;
  assign rif1.rd_en   = rd_en;
  assign rif1.rd_addr = rd_addr;

  pipe_trace_monitor #(.MAX_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .core_reset(core_reset0), .probe(probe),
    .ch_en(ch_en), .halt(halt), .op_err(op_err), .fn_err(fn_err), .arm(arm),
    .post_trig(post_trig), .state(state0), .cycle_count(cycle_count0),
    .stop_cause(stop_cause0), .done(done0), .entries(entries0), .rd(rif0.slave)
  );

  pipe_trace_monitor #(.MAX_CYCLES(50)) dut1 (
    .clock(clock), .reset(reset), .core_reset(core_reset1), .probe(probe),
    .ch_en(ch_en), .halt(halt), .op_err(op_err), .fn_err(fn_err), .arm(arm),
    .post_trig(post_trig), .state(state1), .cycle_count(cycle_count1),
    .stop_cause(stop_cause1), .done(done1), .entries(entries1), .rd(rif1.slave)
  );

  function automatic logic [63:0] mask_probe(input logic [63:0] p, input logic [3:0] en);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (en[i]) m[i*16 +: 16] = p[i*16 +: 16];
    return m;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    probe = '0; ch_en = 4'hF; halt = 0; op_err = 0; fn_err = 0; arm = 0;
    post_trig = '0; rd_en = 0; rd_addr = '0;
  endtask

  // Reset, then RST_HOLD+1 edges: the monitor is in IDLE with count 0.
  task automatic go_idle();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (state0 !== 3'd1 || cycle_count0 !== 32'd0) begin
      n_fail++;
      $display("FAIL go_idle: state=%0d count=%0d, want state=1 count=0", state0, cycle_count0);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    n_tests++;
    if (state0 !== 3'd0 || core_reset0 !== 1'b1 || cycle_count0 !== 0 || stop_cause0 !== 0 ||
        entries0 !== 0 || rif0.rd_valid !== 0 || rif0.rd_data !== 0 || rif0.rd_cycle !== 0 || done0 !== 0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d core_reset=%b count=%0d stop=%b entries=%0d rd_valid=%b done=%b",
               state0, core_reset0, cycle_count0, stop_cause0, entries0, rif0.rd_valid, done0);
    end
    reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_tests++;
      if (core_reset0 !== (e < 3) || state0 !== ((e < 3) ? 3'd0 : 3'd1)) begin
        n_fail++;
        $display("FAIL hold_edge%0d: core_reset=%b state=%0d, want core_reset=%b state=%0d",
                 e, core_reset0, state0, (e < 3), (e < 3) ? 0 : 1);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (cycle_count0 !== k) begin
        n_fail++;
        $display("FAIL count_start: got %0d want %0d", cycle_count0, k);
      end
    end
  endtask

  // Model: ARMED during cycles A..T, trigger in cycle T, then min(N,7) more
  // samples. Buffer holds the newest 8 of those; addr 0 is the oldest.
  task automatic run_capture(input string name, input int a, input int t, input int n,
                             input logic [2:0] ev, input logic [3:0] en, input bit fixed,
                             input int xc, input logic [2:0] xev);
    int nc, last, nsamp, ent, first;
    logic [63:0] p;
    logic        ev_ok;
    go_idle();
    ch_en = en;
    post_trig = 4'(n);
    nc = (n > 7) ? 7 : n;
    last = t + nc;
    for (int c = 0; c <= last; c++) begin
      arm = (c == a - 1);
      p = fixed ? 64'hDDDD_CCCC_BBBB_AAAA : {$urandom, $urandom};
      probe = p;
      probe_at[c] = p;
      {fn_err, op_err, halt} = (c == t) ? ev : ((c == xc) ? xev : 3'b000);
      if (c == last) begin
        n_tests++;
        if (done0 !== 1'b0) begin
          n_fail++;
          $display("FAIL %s early_done: done=%b at cycle %0d, want 0", name, done0, c);
        end
      end
      tick();
    end
    arm = 0; halt = 0; op_err = 0; fn_err = 0;
    nsamp = last - a + 1;
    ent   = (nsamp > 8) ? 8 : nsamp;
    first = last - ent + 1;
    n_tests++;
    if (done0 !== 1'b1 || state0 !== 3'd4 || stop_cause0 !== {1'b0, ev} ||
        entries0 !== 4'(ent) || cycle_count0 !== 32'(last + 1)) begin
      n_fail++;
      $display("FAIL %s final: done=%b state=%0d stop=%b entries=%0d count=%0d, want 1 4 %b %0d %0d",
               name, done0, state0, stop_cause0, entries0, cycle_count0, {1'b0, ev}, ent, last + 1);
    end
    halt = 1; op_err = 1; arm = 1;
    repeat (2) tick();
    halt = 0; op_err = 0; arm = 0;
    n_tests++;
    if (cycle_count0 !== 32'(last + 1) || stop_cause0 !== {1'b0, ev} || entries0 !== 4'(ent)) begin
      n_fail++;
      $display("FAIL %s freeze: count=%0d stop=%b entries=%0d", name, cycle_count0, stop_cause0, entries0);
    end
    for (int ad = 0; ad < 8; ad++) begin
      rd_en = 1; rd_addr = 3'(ad);
      tick();
      ev_ok = (ad < ent);
      n_tests++;
      if (rif0.rd_valid !== ev_ok ||
          rif0.rd_cycle !== (ev_ok ? 32'(first + ad) : 32'd0) ||
          rif0.rd_data  !== (ev_ok ? mask_probe(probe_at[first + ad], en) : 64'd0)) begin
        n_fail++;
        $display("FAIL %s read%0d: valid=%b cycle=%0d data=%h, want valid=%b cycle=%0d data=%h",
                 name, ad, rif0.rd_valid, rif0.rd_cycle, rif0.rd_data, ev_ok,
                 ev_ok ? first + ad : 0, ev_ok ? mask_probe(probe_at[first + ad], en) : 64'd0);
      end
    end
    rd_en = 0;
    tick();
    n_tests++;
    if (rif0.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s rd_clear: rd_valid=%b want 0", name, rif0.rd_valid);
    end
  endtask

  task automatic test_halt_post();
    run_capture("halt_post", 5, 10, 2, 3'b001, 4'hF, 0, -1, 3'b000);
  endtask

  task automatic test_wrap();
    run_capture("wrap", 1, 20, 0, 3'b010, 4'hF, 0, -1, 3'b000);
  endtask

  task automatic test_mask();
    run_capture("mask", 2, 4, 1, 3'b001, 4'b0101, 1, -1, 3'b000);
    rd_en = 1; rd_addr = 0;
    tick();
    rd_en = 0;
    n_tests++;
    if (rif0.rd_data !== 64'h0000_CCCC_0000_AAAA) begin
      n_fail++;
      $display("FAIL mask_word: got %h want 0000cccc0000aaaa", rif0.rd_data);
    end
  endtask

  task automatic test_double_trig();
    run_capture("double_trig", 3, 6, 3, 3'b101, 4'hF, 0, 8, 3'b010);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int a, t, n;
      a = $urandom_range(1, 10);
      t = a + $urandom_range(0, 20);
      n = $urandom_range(0, 15);
      run_capture("random", a, t, n, 3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)), 0, -1, 3'b000);
    end
  endtask

  task automatic test_idle_trig();
    go_idle();
    repeat (3) tick();
    op_err = 1;
    tick();
    op_err = 0;
    n_tests++;
    if (done0 !== 1'b1 || stop_cause0 !== 4'b0010 || entries0 !== 0 || cycle_count0 !== 32'd4) begin
      n_fail++;
      $display("FAIL idle_trig: done=%b stop=%b entries=%0d count=%0d, want 1 0010 0 4",
               done0, stop_cause0, entries0, cycle_count0);
    end
  endtask

  task automatic test_timeout();
    int k_done;
    go_idle();
    k_done = -1;
    for (int k = 1; k <= 80 && k_done < 0; k++) begin
      tick();
      if (done1 === 1'b1) k_done = k;
    end
    n_tests++;
    if (k_done != 51) begin
      n_fail++;
      $display("FAIL timeout_edge: done after %0d edges, want 51", k_done);
    end
    n_tests++;
    if (stop_cause1 !== 4'b1000 || entries1 !== 0 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_status: stop=%b entries=%0d nontimeout_done=%b, want 1000 0 0",
               stop_cause1, entries1, done0);
    end
    rd_en = 1; rd_addr = 0;
    tick();
    rd_en = 0;
    n_tests++;
    if (rif1.rd_valid !== 1'b0 || rif1.rd_data !== 0) begin
      n_fail++;
      $display("FAIL timeout_read: rd_valid=%b data=%h, want 0 0", rif1.rd_valid, rif1.rd_data);
    end
  endtask

  task automatic test_abort();
    go_idle();
    post_trig = 4'd5;
    arm = 1;
    tick();
    arm = 0;
    tick();
    halt = 1;
    tick();
    halt = 0;
    rd_en = 1; rd_addr = 0;
    tick();
    n_tests++;
    if (state0 !== 3'd3 || rif0.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_read: state=%0d rd_valid=%b, want 3 0", state0, rif0.rd_valid);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (state0 !== 3'd0 || entries0 !== 0 || core_reset0 !== 1'b1 || cycle_count0 !== 0 ||
        stop_cause0 !== 0 || rif0.rd_valid !== 0) begin
      n_fail++;
      $display("FAIL abort: state=%0d entries=%0d core_reset=%b count=%0d stop=%b rd_valid=%b",
               state0, entries0, core_reset0, cycle_count0, stop_cause0, rif0.rd_valid);
    end
    rd_en = 0;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_halt_post();
    test_wrap();
    test_mask();
    test_double_trig();
    test_idle_trig();
    test_timeout();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
